// File: rtl/multi_expr_pkg.sv
// rtl/multi_expr_pkg.sv - shared types and constants for the multiplier-inverse divider
package multi_expr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int FRAC_DEF   = 8;
  localparam int OFFSET_DEF = 16;
  localparam int DW1_DEF    = 8;
  localparam int DW2_DEF    = 10;
  localparam int RW_DEF     = 8;

endpackage

// File: rtl/multi_expr_div_step.sv
// rtl/multi_expr_div_step.sv - one combinational restoring-division step
module multi_expr_div_step #(
  parameter int DW2 = 10
) (
  input  logic [DW2-1:0] rem_in,
  input  logic           bit_in,
  input  logic [DW2-1:0] divisor,
  output logic [DW2-1:0] rem_out,
  output logic           qbit
);

  logic [DW2:0] rem_sh;
  logic [DW2:0] diff;

  // Shift in the next dividend bit and subtract the divisor when it fits;
  // the remainder stays below the divisor, so DW2 bits always hold it.
  always_comb begin
    rem_sh  = {rem_in, bit_in};
    diff    = rem_sh - {1'b0, divisor};
    qbit    = (rem_sh >= {1'b0, divisor});
    rem_out = qbit ? diff[DW2-1:0] : rem_sh[DW2-1:0];
  end

endmodule

// File: rtl/multi_expression_inv.sv
// rtl/multi_expression_inv.sv - recovers D from Q = K*(D-OFFSET) by iterative division
module multi_expression_inv
  import multi_expr_pkg::*;
#(
  parameter int DW1    = DW1_DEF,
  parameter int DW2    = DW2_DEF,
  parameter int RW     = RW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW2-1:0] K,
  input  logic [RW-1:0]  Q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW1-1:0] D,
  output logic           sat,
  output logic           div_zero
);

  localparam int NQ  = RW + FRAC;
  localparam int CW  = $clog2(NQ);
  localparam int RSW = NQ + 2;
  localparam logic signed [RSW-1:0] D_MAX = RSW'((1 << DW1) - 1);
  localparam logic signed [RSW-1:0] OFS   = RSW'(OFFSET);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NQ-1:0]  dvd_q, dvd_d;
  logic [DW2-1:0] dsr_q, dsr_d;
  logic [DW2-1:0] rem_q, rem_d;
  logic [NQ-1:0]  quot_q, quot_d;
  logic           sign_q, sign_d;
  logic           kzero_q, kzero_d;
  logic           qzero_q, qzero_d;
  logic [DW1-1:0] d_q, d_d;
  logic           sat_q, sat_d;
  logic           dz_q, dz_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [DW2-1:0] step_rem;
  logic           step_qbit;

  logic                  round_up;
  logic [NQ:0]           mag;
  logic signed [RSW-1:0] mag_s;
  logic signed [RSW-1:0] res_s;

  multi_expr_div_step #(.DW2(DW2)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[cnt_q]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  // Round half away from zero, apply sign and offset in a wide signed result.
  always_comb begin
    round_up = ({rem_q, 1'b0} >= {1'b0, dsr_q});
    mag      = {1'b0, quot_q} + {{NQ{1'b0}}, round_up};
    mag_s    = {1'b0, mag};
    res_s    = (sign_q ? -mag_s : mag_s) + OFS;
  end

  // Next-state and datapath: capture on accept, one quotient bit per DIV cycle,
  // finalise in FIN, hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    sign_d  = sign_q;
    kzero_d = kzero_q;
    qzero_d = qzero_q;
    d_d     = d_q;
    sat_d   = sat_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = DIV;
          cnt_d   = CW'(NQ - 1);
          dvd_d   = {Q, {FRAC{1'b0}}};
          sign_d  = K[DW2-1];
          dsr_d   = K[DW2-1] ? (~K + 1'b1) : K;
          kzero_d = (K == '0);
          qzero_d = (Q == '0);
          rem_d   = '0;
          quot_d  = '0;
        end
      end
      DIV: begin
        rem_d  = step_rem;
        quot_d = {quot_q[NQ-2:0], step_qbit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        state_d = DONE;
        if (kzero_q) begin
          dz_d = 1'b1;
          if (qzero_q) begin
            d_d   = DW1'(OFFSET);
            sat_d = 1'b0;
          end else begin
            d_d   = '1;
            sat_d = 1'b1;
          end
        end else begin
          dz_d = 1'b0;
          if (res_s < 0) begin
            d_d   = '0;
            sat_d = 1'b1;
          end else if (res_s > D_MAX) begin
            d_d   = '1;
            sat_d = 1'b1;
          end else begin
            d_d   = res_s[DW1-1:0];
            sat_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      sign_q      <= 1'b0;
      kzero_q     <= 1'b0;
      qzero_q     <= 1'b0;
      d_q         <= '0;
      sat_q       <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      sign_q      <= sign_d;
      kzero_q     <= kzero_d;
      qzero_q     <= qzero_d;
      d_q         <= d_d;
      sat_q       <= sat_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign sat       = sat_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_multi_expression_inv.sv
// tb/tb_multi_expression_inv.sv - directed self-checking bench for multi_expression_inv
module tb_multi_expression_inv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [9:0] K;
  logic [7:0] Q;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] D;
  logic       sat;
  logic       div_zero;

  int total = 0;
  int bad   = 0;

  multi_expression_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .K         (K),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .sat       (sat),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string name, input logic [9:0] k, input logic [7:0] q,
                       input logic [7:0] exp_d, input logic exp_sat, input logic exp_dz,
                       input int hold);
    int n;
    logic [7:0] d_seen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    K = k;
    Q = q;
    @(posedge clk); #1;
    in_valid = 1'b0;
    K = 10'h155;
    Q = 8'hAA;
    chk({name, ".busy"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({name, ".latency"}, n, 32'd17);
    chk({name, ".D"}, {24'd0, D}, {24'd0, exp_d});
    chk({name, ".sat"}, {31'd0, sat}, {31'd0, exp_sat});
    chk({name, ".div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    if (hold > 0) begin
      d_seen = D;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      chk({name, ".hold_D"}, {24'd0, D}, {24'd0, exp_d});
      chk({name, ".hold_sat"}, {31'd0, sat}, {31'd0, exp_sat});
      chk({name, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({name, ".hold_stable"}, {24'd0, D}, {24'd0, d_seen});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, ".valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    K         = '0;
    Q         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.D", {24'd0, D}, 32'd0);
    chk("rst.sat", {31'd0, sat}, 32'd0);
    chk("rst.div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel.in_ready_high", {31'd0, in_ready}, 32'd1);

    do_op("k256_q100", 10'd256, 8'd100, 8'd116, 1'b0, 1'b0, 10);
    do_op("k128_q50", 10'd128, 8'd50, 8'd116, 1'b0, 1'b0, 0);
    do_op("k3_q1", 10'd3, 8'd1, 8'd101, 1'b0, 1'b0, 0);
    do_op("km512_q1", 10'h200, 8'd1, 8'd15, 1'b0, 1'b0, 0);
    do_op("km256_q10", 10'h300, 8'd10, 8'd6, 1'b0, 1'b0, 0);
    do_op("km256_q20", 10'h300, 8'd20, 8'd0, 1'b1, 1'b0, 0);
    do_op("k3_q255", 10'd3, 8'd255, 8'd255, 1'b1, 1'b0, 0);
    do_op("k0_q7", 10'd0, 8'd7, 8'd255, 1'b1, 1'b1, 0);
    do_op("k0_q0", 10'd0, 8'd0, 8'd16, 1'b0, 1'b1, 0);

    in_valid = 1'b1;
    K = 10'd128;
    Q = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort.D", {24'd0, D}, 32'd0);
    chk("abort.div_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.no_result", {31'd0, out_valid}, 32'd0);
    do_op("after_abort", 10'd256, 8'd100, 8'd116, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
